// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO with a one-cycle registered read.
// It issues FIFO reads, captures the returned words into a 2-entry buffer and
// presents them on a valid/ready stream. It sustains one word per cycle and never
// reads an empty FIFO.
//
// The controller state is held as (occ_q, inflight_q):
//   idle  : occ_q == 0, inflight_q == 0
//   fetch : inflight_q == 1 (a read issued last cycle returns data this cycle)
//   hold  : occ_q != 0, inflight_q == 0
// These two fields are the state register itself. Keeping them explicit, rather than
// using an encoded state name, lets the read-issue rule be plain arithmetic on them.
module fifo_stream_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_underflow,
  output logic                 fifo_rd_en,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 err_underflow
);

  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d;
  logic [WIDTH-1:0]     buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 pop;
  logic [2:0]           slots;

  // Stream outputs depend only on registered state; no path from m_ready.
  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf0_q;
  assign word_cnt      = cnt_q;
  assign err_underflow = err_q;

  // Read issue: count buffered plus in-flight words, less a word popped this cycle.
  // A read is allowed only while that count stays below the two buffer slots.
  // Gating with res_n keeps the read request low while reset is held.
  always_comb begin
    pop        = m_valid & m_ready;
    slots      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = res_n & en & ~fifo_empty & (slots < 3'd2);
  end

  // Next state: capture returning data, shift on pop, count beats, latch underflow.
  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = fifo_rd_en;
    cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    err_d      = err_q | fifo_underflow;
    case ({inflight_q, pop})
      2'b10: begin
        // Capture only: append at the tail. An in-flight read implies occ_q <= 1.
        if (occ_q == 2'd0) begin
          buf0_d = fifo_rdata;
        end else begin
          buf1_d = fifo_rdata;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Capture and pop together: shift, and the new word takes the freed tail.
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rdata;
        end
      end
      default: ;
    endcase
  end

  // State register; reset discards in-flight reads and all buffered words.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. It contains a queue-based FIFO with
// a registered read, and a reference model that tracks words by the cycle their
// read was issued. Directed sequences cover the corner cases, and a table of
// randomized scenarios drives everything else.
module tb_fifo_stream_reader;

  localparam int W  = 8;
  localparam int CW = 8;  // small counter so the wrap is reached quickly
  localparam int CMASK = (1 << CW) - 1;

  logic          clk;
  logic          res_n;
  logic          en;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_underflow;
  logic          fifo_rd_en;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] word_cnt;
  logic          err_underflow;

  fifo_stream_reader #(
    .WIDTH    (W),
    .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .res_n         (res_n),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .word_cnt      (word_cnt),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents, words written but not yet streamed, and the issue cycles of
  // reads that have not yet been popped.
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           pend[$];
  int           cyc;
  int           cnt_exp;
  bit           err_exp;

  int errors;
  int checks;

  int rd_cnt, valid_cnt, first_rd, first_valid, last_valid;
  bit dut_wrap;
  logic [CW-1:0] prev_wc;

  typedef struct {
    int nwords;
    int push_pct;
    int en_pct;
    int ready_pct;
    int exp_cnt;
    bit exp_wrap;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rd_cnt      = 0;
    valid_cnt   = 0;
    first_rd    = -1;
    first_valid = -1;
    last_valid  = -1;
    dut_wrap    = 1'b0;
    prev_wc     = word_cnt;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: check at the negedge, then advance the models after the posedge.
  task automatic step();
    bit   mv, pop, rde;
    logic rd_dut;
    @(negedge clk);
    // A word read in cycle N is visible on the stream from cycle N+2.
    mv  = res_n && pend.size() > 0 && (pend[0] + 2 <= cyc);
    pop = mv && m_ready;
    rde = res_n && en && fq.size() > 0 && ((pend.size() - int'(pop)) < 2);
    chk("m_valid", m_valid, mv);
    chk("fifo_rd_en", fifo_rd_en, rde);
    chk("word_cnt", word_cnt, cnt_exp);
    chk("err_underflow", err_underflow, err_exp);
    if (mv) chk("m_data", m_data, exp_q[0]);
    if (!res_n) chk("m_data_in_reset", m_data, 0);
    if (fq.size() == 0) chk("read_on_empty", fifo_rd_en, 0);
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    if (word_cnt == '0 && prev_wc == CW'(CMASK)) dut_wrap = 1'b1;
    prev_wc = word_cnt;
    rd_dut  = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(pend.pop_front());
      void'(exp_q.pop_front());
      cnt_exp = (cnt_exp + 1) & CMASK;
    end
    if (rde) pend.push_back(cyc);
    if (res_n && fifo_underflow) err_exp = 1'b1;
    if (rd_dut === 1'b1 && fq.size() > 0) fifo_rdata = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  // Asynchronous reset pulse. Outputs must clear at once. Words pushed while
  // reset is held must not be read until reset is released.
  task automatic do_reset(input int npush);
    res_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    fq.delete();
    exp_q.delete();
    pend.delete();
    cnt_exp    = 0;
    err_exp    = 1'b0;
    fifo_empty = 1'b1;
    for (int i = 0; i < npush; i++) push(W'(8'hC0 + i));
    step();
    step();
    res_n = 1'b1;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    cyc            = 0;
    cnt_exp        = 0;
    err_exp        = 1'b0;
    res_n          = 1'b1;
    en             = 1'b0;
    fifo_empty     = 1'b1;
    fifo_rdata     = '0;
    fifo_underflow = 1'b0;
    m_ready        = 1'b0;

    vecs[0] = '{nwords: 300, push_pct: 100, en_pct: 100, ready_pct: 100, exp_cnt: 300 & CMASK,
                exp_wrap: 1'b1};
    vecs[1] = '{nwords: 40, push_pct: 30, en_pct: 100, ready_pct: 100, exp_cnt: 40,
                exp_wrap: 1'b0};
    vecs[2] = '{nwords: 60, push_pct: 100, en_pct: 50, ready_pct: 40, exp_cnt: 60,
                exp_wrap: 1'b0};
    vecs[3] = '{nwords: 80, push_pct: 60, en_pct: 70, ready_pct: 20, exp_cnt: 80,
                exp_wrap: 1'b0};
    vecs[4] = '{nwords: 50, push_pct: 100, en_pct: 100, ready_pct: 60, exp_cnt: 50,
                exp_wrap: 1'b0};

    #1;
    do_reset(0);

    // Single word.
    clear_stats();
    en      = 1'b1;
    m_ready = 1'b1;
    begin
      int s;
      s = cyc;
      push(8'hA5);
      repeat (6) step();
      chk("single_rd_cnt", rd_cnt, 1);
      chk("single_first_rd", first_rd, s);
      chk("single_first_valid", first_valid, s + 2);
      chk("single_valid_cnt", valid_cnt, 1);
      chk("single_word_cnt", word_cnt, 1);
    end

    // Burst of 16 preloaded words.
    do_reset(0);
    en      = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(W'(i));
    step();
    step();
    clear_stats();
    en      = 1'b1;
    m_ready = 1'b1;
    repeat (22) step();
    chk("burst_valid_cnt", valid_cnt, 16);
    chk("burst_back_to_back", last_valid - first_valid, 15);
    chk("burst_word_cnt", word_cnt, 16);
    chk("burst_err", err_underflow, 0);

    // Backpressure from the empty state.
    do_reset(0);
    en      = 1'b1;
    m_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) push(W'(i));
    repeat (10) step();
    chk("bp_rd_cnt", rd_cnt, 2);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_m_data", m_data, 0);
    m_ready = 1'b1;
    repeat (14) step();
    chk("bp_total_rd", rd_cnt, 8);
    chk("bp_word_cnt", word_cnt, 8);

    // Enable gating right after one read.
    do_reset(0);
    en      = 1'b1;
    m_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 4; i++) push(W'(8'h40 + i));
    step();
    en = 1'b0;
    repeat (5) step();
    chk("en_gate_rd_cnt", rd_cnt, 1);
    chk("en_gate_valid_cnt", valid_cnt, 1);
    en = 1'b1;
    repeat (8) step();
    chk("en_resume_valid_cnt", valid_cnt, 4);
    chk("en_resume_word_cnt", word_cnt, 4);

    // Reset mid-burst, with new words arriving while reset is held.
    do_reset(0);
    en      = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(W'(8'h80 + i));
    repeat (5) step();
    chk("mid_burst_valid", m_valid, 1);
    do_reset(3);
    clear_stats();
    repeat (8) step();
    chk("post_rst_valid_cnt", valid_cnt, 3);
    chk("post_rst_word_cnt", word_cnt, 3);

    // Sticky underflow flag.
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    repeat (3) step();
    chk("underflow_sticky", err_underflow, 1);
    do_reset(0);
    step();
    chk("underflow_cleared", err_underflow, 0);

    // Randomized scenarios from the table.
    foreach (vecs[v]) begin
      int pushed;
      int budget;
      do_reset(0);
      clear_stats();
      pushed = 0;
      budget = 5000;
      while ((pushed < vecs[v].nwords || exp_q.size() > 0) && budget > 0) begin
        en      = ($urandom_range(99) < 32'(vecs[v].en_pct));
        m_ready = ($urandom_range(99) < 32'(vecs[v].ready_pct));
        if (pushed < vecs[v].nwords && $urandom_range(99) < 32'(vecs[v].push_pct)) begin
          push(W'($urandom));
          pushed++;
        end
        step();
        budget--;
      end
      en      = 1'b1;
      m_ready = 1'b1;
      repeat (4) step();
      chk("rand_budget_left", (budget > 0), 1);
      chk("rand_word_cnt", word_cnt, vecs[v].exp_cnt);
      chk("rand_wrap", dut_wrap, vecs[v].exp_wrap);
      chk("rand_err", err_underflow, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
